// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state type, refund sentinel and default sizing for the vending controller
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_MONEY = 3'd2,
    ST_DISPENSE   = 3'd3,
    ST_REFUND     = 3'd4
  } vend_state_e;

  localparam int DEF_NUM_ITEMS  = 1000;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_COST_W     = 16;
  localparam int DEF_COIN_W     = 8;
  localparam int DEF_AVAIL_W    = 8;
  localparam int DEF_MAX_CREDIT = 4095;
  localparam int DEF_MEM_TMO    = 15;
  localparam int DEF_IDLE_TMO   = 1000;

  // Refund pulses report an all-ones item index
  localparam logic [DEF_ADDR_W-1:0] REFUND_ITEM = '1;

endpackage

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - credit register with ceiling check, coin reject strobe and clear
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int COST_W     = DEF_COST_W,
  parameter int COIN_W     = DEF_COIN_W,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_value,
  input  logic              accept_en,
  input  logic              clear,
  output logic [COST_W-1:0] credit,
  output logic              coin_ok,
  output logic              reject
);

  localparam logic [COST_W:0] CREDIT_CEIL = (COST_W+1)'(MAX_CREDIT);

  logic [COST_W-1:0] credit_q, credit_d;
  logic              reject_q, reject_d;
  logic [COST_W:0]   sum;

  // One extra bit on the sum so the ceiling compare never sees a wrapped value
  always_comb begin
    sum      = {1'b0, credit_q} + {{(COST_W+1-COIN_W){1'b0}}, coin_value};
    coin_ok  = coin_valid && accept_en && (sum <= CREDIT_CEIL);
    reject_d = coin_valid && !coin_ok;
    credit_d = credit_q;
    if (clear) begin
      credit_d = '0;
    end else if (coin_ok) begin
      credit_d = sum[COST_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign credit = credit_q;
  assign reject = reject_q;

endmodule

// File: rtl/vend_ctrl_fsm_p.sv
// rtl/vend_ctrl_fsm_p.sv - vending controller: item fetch with timeout, payment, dispense and refund
module vend_ctrl_fsm_p
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = DEF_NUM_ITEMS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int COST_W     = DEF_COST_W,
  parameter int COIN_W     = DEF_COIN_W,
  parameter int AVAIL_W    = DEF_AVAIL_W,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int MEM_TMO    = DEF_MEM_TMO,
  parameter int IDLE_TMO   = DEF_IDLE_TMO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_mode,
  input  logic               sync_currency_valid,
  input  logic [COIN_W-1:0]  sync_currency_value,
  input  logic               sync_item_select_valid,
  input  logic [ADDR_W-1:0]  sync_item_select,
  input  logic               sync_cancel,
  output logic               mem_read_en,
  output logic [ADDR_W-1:0]  mem_read_addr,
  input  logic [COST_W-1:0]  mem_item_cost,
  input  logic [AVAIL_W-1:0] mem_item_available,
  input  logic               mem_data_valid,
  output logic               mem_update_en,
  output logic [ADDR_W-1:0]  mem_update_addr,
  output logic               item_dispense_valid,
  output logic [ADDR_W-1:0]  item_dispense,
  output logic [COST_W-1:0]  currency_change,
  output logic               currency_reject,
  output logic               busy
);

  localparam int MEM_CW  = $clog2(MEM_TMO + 1);
  localparam int IDLE_CW = $clog2(IDLE_TMO + 1);
  localparam logic [MEM_CW-1:0]  MEM_LAST   = MEM_CW'(MEM_TMO - 1);
  localparam logic [IDLE_CW-1:0] IDLE_LAST  = IDLE_CW'(IDLE_TMO - 1);
  localparam logic [ADDR_W:0]    ITEM_LIMIT = (ADDR_W+1)'(NUM_ITEMS);
  localparam logic [ADDR_W-1:0]  REFUND_IDX = {ADDR_W{REFUND_ITEM[0]}};

  vend_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  item_q, item_d;
  logic [COST_W-1:0]  cost_q, cost_d;
  logic [AVAIL_W-1:0] stock_q, stock_d;
  logic [MEM_CW-1:0]  mem_cnt_q, mem_cnt_d;
  logic [IDLE_CW-1:0] idle_cnt_q, idle_cnt_d;
  logic               mem_read_en_q, mem_read_en_d;
  logic [ADDR_W-1:0]  mem_read_addr_q, mem_read_addr_d;
  logic               mem_update_en_q, mem_update_en_d;
  logic [ADDR_W-1:0]  mem_update_addr_q, mem_update_addr_d;
  logic               dispense_valid_q, dispense_valid_d;
  logic [ADDR_W-1:0]  dispense_item_q, dispense_item_d;
  logic [COST_W-1:0]  change_q, change_d;
  logic               busy_q, busy_d;

  logic [COST_W-1:0]  credit;
  logic               coin_ok;
  logic               coin_accept_en;
  logic               credit_clear;

  assign coin_accept_en = (state_q == ST_FETCH) || (state_q == ST_WAIT_MONEY);
  assign credit_clear   = (state_q == ST_DISPENSE) || (state_q == ST_REFUND);

  vend_credit_acc #(
    .COST_W     (COST_W),
    .COIN_W     (COIN_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .coin_valid (sync_currency_valid),
    .coin_value (sync_currency_value),
    .accept_en  (coin_accept_en),
    .clear      (credit_clear),
    .credit     (credit),
    .coin_ok    (coin_ok),
    .reject     (currency_reject)
  );

  always_comb begin
    state_d           = state_q;
    item_d            = item_q;
    cost_d            = cost_q;
    stock_d           = stock_q;
    mem_cnt_d         = mem_cnt_q;
    idle_cnt_d        = idle_cnt_q;
    mem_read_en_d     = 1'b0;
    mem_read_addr_d   = '0;
    mem_update_en_d   = 1'b0;
    mem_update_addr_d = '0;
    dispense_valid_d  = 1'b0;
    dispense_item_d   = '0;
    change_d          = '0;
    case (state_q)
      ST_IDLE: begin
        if (sync_item_select_valid && !cfg_mode && ({1'b0, sync_item_select} < ITEM_LIMIT)) begin
          item_d          = sync_item_select;
          mem_read_en_d   = 1'b1;
          mem_read_addr_d = sync_item_select;
          mem_cnt_d       = '0;
          state_d         = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_data_valid) begin
          cost_d     = mem_item_cost;
          stock_d    = mem_item_available;
          idle_cnt_d = '0;
          state_d    = ST_WAIT_MONEY;
        end else if (mem_cnt_q == MEM_LAST) begin
          state_d = ST_REFUND;
        end else begin
          mem_cnt_d = mem_cnt_q + 1'b1;
        end
      end
      ST_WAIT_MONEY: begin
        // Decisions use the registered credit; a coin this cycle still lands before DISPENSE/REFUND
        if (sync_cancel || cfg_mode) begin
          state_d = ST_REFUND;
        end else if (stock_q == '0) begin
          state_d = ST_REFUND;
        end else if (credit >= cost_q) begin
          state_d = ST_DISPENSE;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = ST_REFUND;
        end else begin
          idle_cnt_d = coin_ok ? '0 : idle_cnt_q + 1'b1;
        end
      end
      ST_DISPENSE: begin
        dispense_valid_d  = 1'b1;
        dispense_item_d   = item_q;
        change_d          = credit - cost_q;
        mem_update_en_d   = 1'b1;
        mem_update_addr_d = item_q;
        state_d           = ST_IDLE;
      end
      ST_REFUND: begin
        dispense_valid_d = 1'b1;
        dispense_item_d  = REFUND_IDX;
        change_d         = credit;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      item_q            <= '0;
      cost_q            <= '0;
      stock_q           <= '0;
      mem_cnt_q         <= '0;
      idle_cnt_q        <= '0;
      mem_read_en_q     <= 1'b0;
      mem_read_addr_q   <= '0;
      mem_update_en_q   <= 1'b0;
      mem_update_addr_q <= '0;
      dispense_valid_q  <= 1'b0;
      dispense_item_q   <= '0;
      change_q          <= '0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      item_q            <= item_d;
      cost_q            <= cost_d;
      stock_q           <= stock_d;
      mem_cnt_q         <= mem_cnt_d;
      idle_cnt_q        <= idle_cnt_d;
      mem_read_en_q     <= mem_read_en_d;
      mem_read_addr_q   <= mem_read_addr_d;
      mem_update_en_q   <= mem_update_en_d;
      mem_update_addr_q <= mem_update_addr_d;
      dispense_valid_q  <= dispense_valid_d;
      dispense_item_q   <= dispense_item_d;
      change_q          <= change_d;
      busy_q            <= busy_d;
    end
  end

  assign mem_read_en         = mem_read_en_q;
  assign mem_read_addr       = mem_read_addr_q;
  assign mem_update_en       = mem_update_en_q;
  assign mem_update_addr     = mem_update_addr_q;
  assign item_dispense_valid = dispense_valid_q;
  assign item_dispense       = dispense_item_q;
  assign currency_change     = change_q;
  assign busy                = busy_q;

endmodule
